// File: rtl/joypad_ctrl.sv
// Joypad front end: debounces five push buttons, decodes a quadrature rotary
// encoder into timed Start/Select presses, and produces the key mask and interrupt.
module joypad_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES  = 41943,
  parameter int unsigned ROT_PULSE_CYCLES = 419430
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_n,
  input  logic       sw_s,
  input  logic       sw_e,
  input  logic       sw_w,
  input  logic       sw_c,
  input  logic       rot_a,
  input  logic       rot_b,
  input  logic       map_sel,
  input  logic       en,
  output logic [7:0] key,
  output logic       key_int
);

  localparam int unsigned NBTN = 5;
  localparam int unsigned B_N  = 0;
  localparam int unsigned B_S  = 1;
  localparam int unsigned B_E  = 2;
  localparam int unsigned B_W  = 3;
  localparam int unsigned B_C  = 4;

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PW   = $clog2(ROT_PULSE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0]   PULSE_LOAD = PW'(ROT_PULSE_CYCLES);

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] btn_s1;
  logic [NBTN-1:0] btn_s2;
  logic [NBTN-1:0] stable;
  logic [DB_W-1:0] db_cnt [NBTN];

  logic [1:0]      rot_s1;
  logic [1:0]      rot_s2;
  logic [1:0]      rot_prev;
  logic [2:0]      acc;
  logic [2:0]      acc_nxt;
  logic [3:0]      acc_sum;
  logic            step_cw;
  logic            det_cw;
  logic            det_ccw;
  logic [PW-1:0]   pulse_cnt;
  logic            pulse_cw;

  logic            active_map;
  logic [7:0]      btn_key;
  logic [7:0]      rot_key;
  logic [7:0]      key_next;

  assign btn_raw = {sw_c, sw_w, sw_e, sw_s, sw_n};

  // Two-flop synchronizers for every asynchronous input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      rot_s1 <= '0;
      rot_s2 <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      rot_s1 <= {rot_a, rot_b};
      rot_s2 <= rot_s1;
    end
  end

  // Per-button debounce: stable follows synced only after a full run of disagreement
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= '0;
      for (int i = 0; i < NBTN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (btn_s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= btn_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Quadrature step decode; a full detent is four steps ending in 00
  always_comb begin
    step_cw = 1'b0;
    acc_nxt = acc;
    det_cw  = 1'b0;
    det_ccw = 1'b0;
    case ({rot_prev, rot_s2})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step_cw = 1'b1;
      default:                            step_cw = 1'b0;
    endcase
    acc_sum = {acc[2], acc} + (step_cw ? 4'b0001 : 4'b1111);
    if (rot_s2 != rot_prev) begin
      if ((rot_s2 ^ rot_prev) == 2'b11) begin
        acc_nxt = '0;
      end else if (rot_s2 == 2'b00) begin
        acc_nxt = '0;
        det_cw  = (acc_sum == 4'b0100);
        det_ccw = (acc_sum == 4'b1100);
      end else begin
        acc_nxt = acc_sum[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rot_prev  <= '0;
      acc       <= '0;
      pulse_cnt <= '0;
      pulse_cw  <= 1'b0;
    end else begin
      rot_prev <= rot_s2;
      acc      <= acc_nxt;
      if (det_cw || det_ccw) begin
        pulse_cnt <= PULSE_LOAD;
        pulse_cw  <= det_cw;
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - PW'(1);
      end
    end
  end

  // Map switches only with every button released so no bit can be left stuck
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_map <= 1'b0;
    end else if (stable == '0) begin
      active_map <= map_sel;
    end
  end

  always_comb begin
    btn_key = '0;
    rot_key = '0;
    if (!active_map) begin
      btn_key[0] = stable[B_E];
      btn_key[1] = stable[B_W];
      btn_key[2] = stable[B_N];
      btn_key[3] = stable[B_S];
      btn_key[4] = stable[B_C];
    end else begin
      btn_key[4] = stable[B_N] | stable[B_C];
      btn_key[5] = stable[B_S];
      btn_key[6] = stable[B_W];
      btn_key[7] = stable[B_E];
    end
    if (pulse_cnt != '0) begin
      if (pulse_cw) rot_key[7] = 1'b1;
      else          rot_key[6] = 1'b1;
    end
    key_next = (btn_key | rot_key) & {8{en}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key     <= '0;
      key_int <= 1'b0;
    end else begin
      key     <= key_next;
      key_int <= |(key_next & ~key);
    end
  end

endmodule

// File: tb/tb_joypad_ctrl.sv
// Scoreboard bench for joypad_ctrl: stimulus queues expected key events,
// a negedge monitor matches each key change against the queue and timing window.
module tb_joypad_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned RP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_n = 1'b0, sw_s = 1'b0, sw_e = 1'b0, sw_w = 1'b0, sw_c = 1'b0;
  logic       rot_a = 1'b0, rot_b = 1'b0;
  logic       map_sel = 1'b0;
  logic       en = 1'b1;
  logic [7:0] key;
  logic       key_int;

  joypad_ctrl #(.DEBOUNCE_CYCLES(DB), .ROT_PULSE_CYCLES(RP)) dut (
    .clk(clk), .rst(rst),
    .sw_n(sw_n), .sw_s(sw_s), .sw_e(sw_e), .sw_w(sw_w), .sw_c(sw_c),
    .rot_a(rot_a), .rot_b(rot_b),
    .map_sel(map_sel), .en(en),
    .key(key), .key_int(key_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] key;
    logic       kint;
    logic       rel;
    int         lo;
    int         hi;
  } exp_t;

  exp_t       sb[$];
  int         ncyc = -1;
  int         last_evt = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] prev_key = 8'h00;
  logic       done = 1'b0;

  // Monitor: every key change must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    int lo;
    int hi;
    ncyc++;
    if (key !== prev_key) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL key_change cyc=%0d got key=%h key_int=%b, required no change from %h",
                 ncyc, key, key_int, prev_key);
      end else begin
        e  = sb.pop_front();
        lo = e.rel ? last_evt + e.lo : e.lo;
        hi = e.rel ? last_evt + e.hi : e.hi;
        if (key !== e.key || key_int !== e.kint || ncyc < lo || ncyc > hi) begin
          errors++;
          $display("FAIL key_event cyc=%0d got key=%h key_int=%b, required key=%h key_int=%b in cycles %0d..%0d",
                   ncyc, key, key_int, e.key, e.kint, lo, hi);
        end
      end
      last_evt = ncyc;
      prev_key = key;
    end else if (!rst) begin
      checks++;
      if (key !== 8'h00 || key_int !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got key=%h key_int=%b, required key=00 key_int=0",
                 ncyc, key, key_int);
      end
    end else begin
      checks++;
      if (key_int !== 1'b0) begin
        errors++;
        $display("FAIL key_int_idle cyc=%0d got key_int=%b with key=%h unchanged, required 0",
                 ncyc, key_int, key);
      end
    end
    if (done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL pending_events got %0d unseen, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  function automatic int now_cyc();
    return ncyc + 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input logic [7:0] k, input logic ki, input int lo, input int hi);
    exp_t e;
    e.key = k; e.kint = ki; e.rel = 1'b0; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic expect_rel(input logic [7:0] k, input logic ki, input int lo, input int hi);
    exp_t e;
    e.key = k; e.kint = ki; e.rel = 1'b1; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: sw_n = v;
      1: sw_s = v;
      2: sw_e = v;
      3: sw_w = v;
      default: sw_c = v;
    endcase
  endtask

  // Change one button and expect the key after the debounce latency
  task automatic press(input int idx, input logic v, input logic [7:0] k, input logic ki);
    int t;
    set_btn(idx, v);
    t = now_cyc();
    expect_at(k, ki, t + DB + 2, t + DB + 3);
    tick(12);
  endtask

  task automatic phase(input logic [1:0] ab, input int hold);
    {rot_a, rot_b} = ab;
    tick(hold);
  endtask

  initial begin
    int t;
    #1 rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(3);

    // Single d-pad press and release
    press(0, 1'b1, 8'h04, 1'b1);
    press(0, 1'b0, 8'h00, 1'b0);

    // Bouncing East must be filtered, then a clean press registers once
    sw_e = 1'b1; tick(2); sw_e = 1'b0; tick(2);
    sw_e = 1'b1; tick(2); sw_e = 1'b0; tick(2);
    press(2, 1'b1, 8'h01, 1'b1);
    press(2, 1'b0, 8'h00, 1'b0);

    press(3, 1'b1, 8'h02, 1'b1);
    press(3, 1'b0, 8'h00, 1'b0);
    press(1, 1'b1, 8'h08, 1'b1);
    press(1, 1'b0, 8'h00, 1'b0);

    // Full CW detent: Start for exactly RP cycles
    phase(2'b01, 3); phase(2'b11, 3); phase(2'b10, 3);
    {rot_a, rot_b} = 2'b00;
    t = now_cyc();
    expect_at(8'h80, 1'b1, t + 3, t + 6);
    expect_rel(8'h00, 1'b0, RP, RP);
    tick(16);

    // CW detent, then a fast CCW detent while Start is still active
    phase(2'b01, 3); phase(2'b11, 3); phase(2'b10, 3);
    {rot_a, rot_b} = 2'b00;
    t = now_cyc();
    expect_at(8'h80, 1'b1, t + 3, t + 6);
    expect_rel(8'h40, 1'b1, 1, 7);
    expect_rel(8'h00, 1'b0, RP, RP);
    tick(1);
    phase(2'b10, 1); phase(2'b11, 1); phase(2'b01, 1); phase(2'b00, 16);

    // Illegal jumps and a half detent: no pulse at all
    phase(2'b01, 3); phase(2'b11, 3); phase(2'b10, 3);
    phase(2'b01, 3); phase(2'b00, 3);
    phase(2'b11, 3); phase(2'b10, 3); phase(2'b00, 3);
    phase(2'b01, 3); phase(2'b11, 3); phase(2'b01, 3); phase(2'b00, 12);

    // Map change deferred while Center is held
    press(4, 1'b1, 8'h10, 1'b1);
    map_sel = 1'b1;
    tick(10);
    press(4, 1'b0, 8'h00, 1'b0);
    press(1, 1'b1, 8'h20, 1'b1);
    press(1, 1'b0, 8'h00, 1'b0);
    press(0, 1'b1, 8'h10, 1'b1);
    press(0, 1'b0, 8'h00, 1'b0);
    press(2, 1'b1, 8'h80, 1'b1);
    press(2, 1'b0, 8'h00, 1'b0);
    press(3, 1'b1, 8'h40, 1'b1);
    press(3, 1'b0, 8'h00, 1'b0);

    // North and Center together both drive A
    sw_n = 1'b1; sw_c = 1'b1;
    t = now_cyc();
    expect_at(8'h10, 1'b1, t + DB + 2, t + DB + 3);
    tick(12);
    sw_n = 1'b0; sw_c = 1'b0;
    t = now_cyc();
    expect_at(8'h00, 1'b0, t + DB + 2, t + DB + 3);
    tick(12);
    map_sel = 1'b0;
    tick(3);

    // Enable gating: held press hidden while halted, appears the cycle after en rises
    en = 1'b0;
    sw_n = 1'b1;
    tick(12);
    en = 1'b1;
    t = now_cyc();
    expect_at(8'h04, 1'b1, t + 1, t + 1);
    tick(4);
    en = 1'b0;
    t = now_cyc();
    expect_at(8'h00, 1'b0, t + 1, t + 1);
    tick(4);
    en = 1'b1;
    t = now_cyc();
    expect_at(8'h04, 1'b1, t + 1, t + 1);
    tick(4);
    press(0, 1'b0, 8'h00, 1'b0);

    // Reset mid-pulse clears at once; a button held through reset release then registers
    phase(2'b01, 3); phase(2'b11, 3); phase(2'b10, 3);
    {rot_a, rot_b} = 2'b00;
    t = now_cyc();
    expect_at(8'h80, 1'b1, t + 3, t + 6);
    tick(8);
    rst = 1'b0;
    sw_n = 1'b1;
    t = now_cyc();
    expect_at(8'h00, 1'b0, t, t);
    tick(3);
    rst = 1'b1;
    t = now_cyc();
    expect_at(8'h04, 1'b1, t + DB + 2, t + DB + 3);
    tick(12);
    press(0, 1'b0, 8'h00, 1'b0);
    tick(16);

    done = 1'b1;
    tick(4);
    $display("FAIL monitor_finish got no summary, required summary after done");
    $fatal(1);
  end

endmodule

// File: doc/joypad_ctrl.md
JOYPAD_CTRL -- requirements
Module: joypad_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 41943, number of consecutive clk cycles an input must differ before its debounced state changes (about 10 ms at 4.19 MHz).
REQ-002 Parameter ROT_PULSE_CYCLES, default 419430, length in clk cycles of the synthetic key press generated per rotary detent (about 100 ms).
REQ-003 clk  input  1  Game Boy core clock (clk_gb); all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 sw_n, sw_s, sw_e, sw_w, sw_c  input  1 each  raw, asynchronous, active-high push buttons.
REQ-006 rot_a, rot_b  input  1 each  raw, asynchronous rotary-encoder quadrature phases.
REQ-007 map_sel  input  1  key map select: 0 = d-pad map, 1 = action map.
REQ-008 en  input  1  when low (debugger halted), all key outputs are forced released.
REQ-009 key  output  8  pressed mask, 1 = pressed; bits are [0] Right, [1] Left, [2] Up, [3] Down, [4] A, [5] B, [6] Select, [7] Start.
REQ-010 key_int  output  1  one-cycle pulse on any key 0->1 transition (joypad interrupt request).

Function
REQ-011 Every raw input passes through a 2-flop synchronizer before any other use.
REQ-012 Each synchronized button has its own counter and stable bit; the counter increments while the synced value differs from stable and clears to 0 whenever they are equal.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 and the value still differs, stable takes the synced value and the counter clears; glitches shorter than DEBOUNCE_CYCLES cycles never change stable.
REQ-014 After a raw button edge, key updates no earlier than DEBOUNCE_CYCLES+2 and no later than DEBOUNCE_CYCLES+3 cycles later.
REQ-015 The d-pad map (active_map=0) is N->Up, S->Down, E->Right, W->Left, C->A.
REQ-016 The action map (active_map=1) is N->A, S->B, E->Start, W->Select, C->A; bits that are driven by two sources are ORed.
REQ-017 active_map takes map_sel only on a cycle when all five debounced buttons are released; a map_sel change made while any button is held is deferred, so no key bit can stick.
REQ-018 The rotary decoder uses the synced phases {a,b} as a state; the CW sequence is 00->01->11->10->00 and the CCW sequence is its reverse.
REQ-019 The decoder keeps a signed 3-bit accumulator: +1 per valid CW transition, -1 per valid CCW transition.
REQ-020 A transition that changes both phases at once is illegal; it is ignored and clears the accumulator to 0.
REQ-021 On entering state 00 with accumulator +4, the decoder emits a CW detent; with -4, a CCW detent; the accumulator then clears.
REQ-022 On entering state 00 with any other accumulator value, the accumulator clears and no detent is emitted.
REQ-023 A CW detent loads the pulse counter with ROT_PULSE_CYCLES and sets pulse direction to Start; a CCW detent does the same with Select.
REQ-024 Start or Select is asserted while the pulse counter is nonzero; the counter decrements by 1 per cycle.
REQ-025 A detent arriving while a pulse is active reloads the counter and overwrites the direction; the opposite key deasserts in that same cycle.
REQ-026 key is registered as (button map OR rotary pulse) AND en; when en is low, key = 8'h00.
REQ-027 When en is low, the debounce logic and the rotary decoder keep running.
REQ-028 key_int = |(key_next & ~key), registered, so it is high for exactly one cycle per press event.
REQ-029 key_int is never asserted on release events, and never while en is low.

Reset
REQ-030 While rst = 0, all synchronizers, stable bits, counters and accumulator are 0, the pulse counter is 0, active_map = 0, key = 8'h00 and key_int = 0.
REQ-031 Reset asserted mid-debounce or mid-pulse aborts it; after release, inputs are re-evaluated from the cleared state.
REQ-032 An input held at 1 through reset release registers as a press after the normal debounce latency and raises key_int once.

Verification (DEBOUNCE_CYCLES=4, ROT_PULSE_CYCLES=8)
REQ-033 Bench scenario: map_sel=0, en=1, sw_n held high -> key=8'h04 within 6-7 cycles with a single key_int pulse; release -> key=8'h00 with no key_int.
REQ-034 Bench scenario: sw_e bouncing 1,0,1,0 at 2-cycle intervals, then stable 1 -> key stays 8'h00 during the bounce, then key=8'h01 with exactly one key_int.
REQ-035 Bench scenario: one full CW detent (00,01,11,10,00, each phase held 3 cycles) -> key[7]=1 for exactly 8 cycles; a CCW detent during that pulse -> key[7]=0 and key[6]=1 in the same cycle.
REQ-036 Bench scenario: phases jump 00->11 mid-sequence -> no detent and key unchanged; a half detent that returns to 00 -> no pulse.
REQ-037 Bench scenario: sw_c held, map_sel toggled 0->1 -> key=8'h10 persists; after release and one cycle, map=1, so sw_s press gives key=8'h20.
REQ-038 Bench scenario: en=0 with sw_n held -> key=8'h00 and key_int=0; en->1 -> key=8'h04 next cycle with one key_int; rst pulsed low mid-pulse -> key=8'h00 immediately.
